uart_frame_decoder: RTL and testbench
=====================================

Name: uart_frame_decoder

Overview:
Sits directly downstream of uart_rx. It consumes the one-cycle o_Rx_DV/o_Rx_Byte pulses and assembles framed packets of the form SOF, LEN, LEN payload bytes, CHK. It validates each packet and buffers the payload. Only a frame whose checksum passes is streamed to the consumer, over a valid/ready byte interface; malformed or stalled frames are reported through an error pulse.

Parameters:
MAX_LEN, 16, maximum payload bytes per frame (buffer depth); legal range 1..255.
SOF_BYTE, 8'h7E, start-of-frame marker.
TIMEOUT_CLKS, 43400, maximum idle clocks between bytes inside a frame (10 byte-times at 434 clks/bit); 0 disables the timeout.

Ports:
i_Clock  input  1  system clock (same clock as uart_rx).
i_Reset  input  1  reset, synchronous, active-high.
i_Rx_DV  input  1  byte strobe from uart_rx, one cycle wide.
i_Rx_Byte  input  8  received byte; valid only when i_Rx_DV=1.
o_Data_Valid  output  1  payload byte available.
o_Data_Byte  output  8  payload byte.
o_Data_Last  output  1  high together with the final payload byte of the frame.
i_Data_Ready  input  1  consumer accepts the byte; a transfer occurs when o_Data_Valid && i_Data_Ready.
o_Frame_Len  output  8  LEN of the frame being streamed; held until the next frame begins output.
o_Err_Valid  output  1  one-cycle error pulse.
o_Err_Code  output  2  error code: 1 = bad LEN, 2 = bad checksum, 3 = timeout; 0 when no error.
o_Overrun  output  1  one-cycle pulse when a byte arrives during s_OUTPUT and is dropped.

Behaviour:
- Reset (synchronous, active-high): state goes to s_IDLE. All outputs go to 0, including o_Frame_Len. Index, sum and timeout counters clear. Buffer contents are don't-care. Reset mid-frame or mid-output abandons the frame and generates no error pulse.
- All outputs are registered.
- States:
  - s_IDLE: on DV with byte == SOF_BYTE, go to s_LEN and clear the sum. Any other byte is ignored silently.
  - s_LEN: on DV, if byte == 0 or byte > MAX_LEN, raise error 1 and return to s_IDLE. Otherwise store LEN, set sum = byte, set wr_idx = 0, go to s_PAYLOAD.
  - s_PAYLOAD: on DV, write buf[wr_idx] = byte and add byte to the sum. When wr_idx == LEN-1, go to s_CHECK; otherwise increment wr_idx. A SOF_BYTE value here is treated as data (no resync).
  - s_CHECK: on DV, if (sum + byte) mod 256 == 0, go to s_OUTPUT with rd_idx = 0. Otherwise raise error 2 and go to s_IDLE.
  - s_OUTPUT: o_Data_Valid=1, o_Data_Byte=buf[rd_idx], o_Data_Last=(rd_idx==LEN-1). On each transfer, increment rd_idx. On the transfer with Last=1, drop Valid and Last the next cycle and return to s_IDLE.
- Checksum: CHK = two's complement of the 8-bit wrap-around sum of LEN and all payload bytes.
- Latency: o_Data_Valid rises on the cycle after the DV carrying CHK. With ready held high, one byte transfers per cycle.
- Backpressure: while Valid=1 and Ready=0, Byte and Last hold stable, unbounded.
- Overrun: any DV while in s_OUTPUT, including the cycle of the final transfer, is dropped and pulses o_Overrun the next cycle. The state is unaffected.
- Timeout: active in s_LEN, s_PAYLOAD and s_CHECK.
  - The counter clears on entry to each of these states and on every DV, and increments on every other cycle.
  - When it reaches TIMEOUT_CLKS-1 with no DV that cycle, raise error 3 and go to s_IDLE.
  - A DV arriving in the same cycle takes precedence over the timeout.
  - The counter is 16 bits.
- Error pulse: o_Err_Valid=1 for exactly one cycle, with o_Err_Code valid that cycle and 0 otherwise. Errors are mutually exclusive per cycle.
- o_Frame_Len updates on entry to s_OUTPUT.

Decomposition:
- Shared include uart_pkg.vh holds:
  - state encodings for s_IDLE, s_LEN, s_PAYLOAD, s_CHECK, s_OUTPUT;
  - ERR_NONE, ERR_LEN, ERR_CHK, ERR_TIMEOUT codes;
  - the SOF default value;
  - CLKS_PER_BIT.
- One sub-module: uart_frame_buf, a MAX_LEN x 8 register array with synchronous write and combinational read. The read result is registered in the decoder.

Test Plan:
1. Good frame: 7E 03 11 22 33 97 with ready=1 -> output 11,22,33 on consecutive cycles, Last on 33, o_Frame_Len=3, no error.
2. Bad checksum: 7E 03 11 22 33 98 -> o_Err_Valid one cycle with code 2, no o_Data_Valid. The next good frame decodes correctly.
3. Bad length: 7E 00 and, separately, 7E 11 (17 > MAX_LEN) -> error code 1 each time. Following bytes are ignored until the next 7E.
4. Timeout: 7E 02 AA, then no DV for 43400 clocks -> error code 3 exactly at TIMEOUT_CLKS-1 idle clocks. A DV one clock earlier produces no error.
5. Backpressure and overrun: good frame 7E 02 41 42 7B with ready=0 for 20 cycles -> byte 41 held stable. A DV of 55 during the stall gives an o_Overrun pulse and 55 never appears on the output. Releasing ready yields 41 then 42 with Last.
6. Noise and reset: bytes 00 FF 13 before 7E are ignored. Asserting i_Reset in s_PAYLOAD clears all outputs next cycle, and a fresh frame then decodes correctly.

Source files
------------

// File: rtl/uart_frame_decoder_pkg.sv
// ---------------------------------------------------------------------------
// uart_frame_decoder_pkg
// Shared definitions for the UART frame decoder:
//   - state_t      : decoder FSM state encoding
//   - ERR_*        : error codes reported on o_Err_Code
//   - SOF_DEFAULT  : default start-of-frame marker
//   - CLKS_PER_BIT : UART bit period in system clocks (matches uart_rx)
//   - TIMEOUT_DEFAULT : ten byte-times of idle clocks between bytes
//   - chk_ok()     : checksum acceptance test
//   - idx_width()  : address width for a buffer of a given depth
// ---------------------------------------------------------------------------
package uart_frame_decoder_pkg;

    typedef enum logic [2:0] {
        s_IDLE    = 3'd0,
        s_LEN     = 3'd1,
        s_PAYLOAD = 3'd2,
        s_CHECK   = 3'd3,
        s_OUTPUT  = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0]  SOF_DEFAULT     = 8'h7E;
    localparam int unsigned CLKS_PER_BIT    = 32'd434;
    // 10 byte-times, each 10 bits long
    localparam int unsigned TIMEOUT_DEFAULT = 32'd100 * CLKS_PER_BIT;

    // A frame is good when LEN + payload + CHK wraps to zero.
    function automatic logic chk_ok(input logic [7:0] sum, input logic [7:0] chk);
        logic [7:0] total;
        total = sum + chk;
        return (total == 8'd0);
    endfunction

    // Never return zero so a depth-1 buffer still gets a legal 1-bit address.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 32'd1) ? $clog2(depth) : 32'd1;
    endfunction

endpackage

// File: rtl/uart_frame_decoder_buf.sv
// ---------------------------------------------------------------------------
// uart_frame_decoder_buf
// Payload storage for one frame: DEPTH x 8 register array, synchronous
// write, combinational read. Contents are not reset.
// Ports:
//   clk      : system clock
//   wr_en    : write strobe
//   wr_addr  : write index
//   wr_data  : byte to store
//   rd_addr  : read index
//   rd_data  : byte at rd_addr (combinational)
// ---------------------------------------------------------------------------
module uart_frame_decoder_buf
    import uart_frame_decoder_pkg::*;
#(
    parameter int unsigned DEPTH = 32'd16,
    parameter int unsigned AW    = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem_r [DEPTH];

    // Store payload bytes as they arrive.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/uart_frame_decoder.sv
// ---------------------------------------------------------------------------
// uart_frame_decoder
// Assembles SOF, LEN, LEN payload bytes, CHK frames from uart_rx byte
// strobes, validates length/checksum/inter-byte timeout, buffers the payload
// and streams good frames out over a valid/ready byte interface.
// Ports:
//   i_Clock, i_Reset           : clock, synchronous active-high reset
//   i_Rx_DV, i_Rx_Byte         : byte strobe and byte from uart_rx
//   o_Data_Valid/Byte/Last     : payload stream, Last marks final byte
//   i_Data_Ready               : consumer accept
//   o_Frame_Len                : LEN of the frame being streamed
//   o_Err_Valid, o_Err_Code    : one-cycle error pulse with code
//   o_Overrun                  : one-cycle pulse, byte dropped during output
// ---------------------------------------------------------------------------
module uart_frame_decoder
    import uart_frame_decoder_pkg::*;
#(
    parameter int unsigned MAX_LEN      = 32'd16,
    parameter logic [7:0]  SOF_BYTE     = SOF_DEFAULT,
    parameter int unsigned TIMEOUT_CLKS = TIMEOUT_DEFAULT
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Data_Valid,
    output logic [7:0] o_Data_Byte,
    output logic       o_Data_Last,
    input  logic       i_Data_Ready,
    output logic [7:0] o_Frame_Len,
    output logic       o_Err_Valid,
    output logic [1:0] o_Err_Code,
    output logic       o_Overrun
);

    localparam int unsigned AW        = idx_width(MAX_LEN);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
    localparam logic        TO_EN     = (TIMEOUT_CLKS != 32'd0);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CLKS - 32'd1);

    state_t        state_r;
    logic [7:0]    len_r;
    logic [7:0]    sum_r;
    logic [7:0]    wr_idx_r;
    logic [7:0]    rd_idx_r;
    logic [15:0]   to_cnt_r;

    logic          buf_wr_en_s;
    logic [AW-1:0] rd_addr_s;
    logic [7:0]    rd_data_s;
    logic          timeout_hit_s;
    logic          xfer_s;

    assign buf_wr_en_s   = (state_r == s_PAYLOAD) && i_Rx_DV;
    assign timeout_hit_s = TO_EN && (to_cnt_r == TO_LAST);
    assign xfer_s        = o_Data_Valid && i_Data_Ready;

    // Read address looks one byte ahead so the registered output byte is
    // ready the cycle after CHK (address 0) or after each transfer.
    always_comb begin
        rd_addr_s = {AW{1'b0}};
        if (state_r == s_CHECK) begin
            rd_addr_s = {AW{1'b0}};
        end else begin
            rd_addr_s = rd_idx_r[AW-1:0] + AW'(1);
        end
    end

    uart_frame_decoder_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (i_Clock),
        .wr_en   (buf_wr_en_s),
        .wr_addr (wr_idx_r[AW-1:0]),
        .wr_data (i_Rx_Byte),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    // Frame FSM with all outputs registered.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_r      <= s_IDLE;
            len_r        <= 8'd0;
            sum_r        <= 8'd0;
            wr_idx_r     <= 8'd0;
            rd_idx_r     <= 8'd0;
            to_cnt_r     <= 16'd0;
            o_Data_Valid <= 1'b0;
            o_Data_Byte  <= 8'd0;
            o_Data_Last  <= 1'b0;
            o_Frame_Len  <= 8'd0;
            o_Err_Valid  <= 1'b0;
            o_Err_Code   <= ERR_NONE;
            o_Overrun    <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            o_Err_Valid <= 1'b0;
            o_Err_Code  <= ERR_NONE;
            o_Overrun   <= 1'b0;

            case (state_r)
                s_IDLE: begin
                    to_cnt_r <= 16'd0;
                    if (i_Rx_DV && (i_Rx_Byte == SOF_BYTE)) begin
                        sum_r   <= 8'd0;
                        state_r <= s_LEN;
                    end
                end

                s_LEN: begin
                    if (i_Rx_DV) begin
                        to_cnt_r <= 16'd0;
                        if ((i_Rx_Byte == 8'd0) || (i_Rx_Byte > MAX_LEN_B)) begin
                            o_Err_Valid <= 1'b1;
                            o_Err_Code  <= ERR_LEN;
                            state_r     <= s_IDLE;
                        end else begin
                            len_r    <= i_Rx_Byte;
                            sum_r    <= i_Rx_Byte;
                            wr_idx_r <= 8'd0;
                            state_r  <= s_PAYLOAD;
                        end
                    end else if (timeout_hit_s) begin
                        o_Err_Valid <= 1'b1;
                        o_Err_Code  <= ERR_TIMEOUT;
                        state_r     <= s_IDLE;
                    end else begin
                        to_cnt_r <= to_cnt_r + 16'd1;
                    end
                end

                s_PAYLOAD: begin
                    // SOF values are plain data here; no resync mid-frame.
                    if (i_Rx_DV) begin
                        to_cnt_r <= 16'd0;
                        sum_r    <= sum_r + i_Rx_Byte;
                        if (wr_idx_r == (len_r - 8'd1)) begin
                            state_r <= s_CHECK;
                        end else begin
                            wr_idx_r <= wr_idx_r + 8'd1;
                        end
                    end else if (timeout_hit_s) begin
                        o_Err_Valid <= 1'b1;
                        o_Err_Code  <= ERR_TIMEOUT;
                        state_r     <= s_IDLE;
                    end else begin
                        to_cnt_r <= to_cnt_r + 16'd1;
                    end
                end

                s_CHECK: begin
                    if (i_Rx_DV) begin
                        to_cnt_r <= 16'd0;
                        if (chk_ok(sum_r, i_Rx_Byte)) begin
                            rd_idx_r     <= 8'd0;
                            o_Data_Valid <= 1'b1;
                            o_Data_Byte  <= rd_data_s;
                            o_Data_Last  <= (len_r == 8'd1);
                            o_Frame_Len  <= len_r;
                            state_r      <= s_OUTPUT;
                        end else begin
                            o_Err_Valid <= 1'b1;
                            o_Err_Code  <= ERR_CHK;
                            state_r     <= s_IDLE;
                        end
                    end else if (timeout_hit_s) begin
                        o_Err_Valid <= 1'b1;
                        o_Err_Code  <= ERR_TIMEOUT;
                        state_r     <= s_IDLE;
                    end else begin
                        to_cnt_r <= to_cnt_r + 16'd1;
                    end
                end

                s_OUTPUT: begin
                    to_cnt_r  <= 16'd0;
                    // Incoming bytes cannot be buffered while streaming.
                    o_Overrun <= i_Rx_DV;
                    if (xfer_s) begin
                        if (o_Data_Last) begin
                            o_Data_Valid <= 1'b0;
                            o_Data_Last  <= 1'b0;
                            state_r      <= s_IDLE;
                        end else begin
                            rd_idx_r    <= rd_idx_r + 8'd1;
                            o_Data_Byte <= rd_data_s;
                            o_Data_Last <= ((rd_idx_r + 8'd1) == (len_r - 8'd1));
                        end
                    end
                end

                default: begin
                    o_Data_Valid <= 1'b0;
                    o_Data_Last  <= 1'b0;
                    to_cnt_r     <= 16'd0;
                    state_r      <= s_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_decoder
// Directed scenarios followed by randomized framed traffic. A frame-level
// reference model (queues of collected and pending bytes) predicts every
// output each cycle.
// ---------------------------------------------------------------------------
module tb_uart_frame_decoder;

    localparam int         MAX_LEN = 16;
    localparam int         TO      = 64;
    localparam logic [7:0] SOF     = 8'h7E;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic       dv;
    logic [7:0] rxb;
    logic       rdy;
    logic       data_valid;
    logic [7:0] data_byte;
    logic       data_last;
    logic [7:0] frame_len;
    logic       err_valid;
    logic [1:0] err_code;
    logic       overrun;

    always #5 clk = ~clk;

    uart_frame_decoder #(
        .MAX_LEN      (MAX_LEN),
        .SOF_BYTE     (SOF),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_Rx_DV      (dv),
        .i_Rx_Byte    (rxb),
        .o_Data_Valid (data_valid),
        .o_Data_Byte  (data_byte),
        .o_Data_Last  (data_last),
        .i_Data_Ready (rdy),
        .o_Frame_Len  (frame_len),
        .o_Err_Valid  (err_valid),
        .o_Err_Code   (err_code),
        .o_Overrun    (overrun)
    );

    int n_vec = 0;
    int n_err = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: stalled

    // Reference model: bytes collected since SOF, bytes awaiting delivery,
    // idle cycles since the last in-frame byte, and next-cycle pulses.
    bit         m_collect = 1'b0;
    logic [7:0] m_frame[$];
    logic [7:0] m_out[$];
    int         m_gap = 0;
    logic [7:0] m_len = 8'd0;
    logic [1:0] m_err = 2'd0;
    bit         m_ovr = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit exp_valid;
        exp_valid = (m_out.size() > 0);
        check_eq("valid", 32'(data_valid), 32'(exp_valid));
        if (exp_valid) begin
            check_eq("byte", 32'(data_byte), 32'(m_out[0]));
        end
        check_eq("last", 32'(data_last), 32'(exp_valid && (m_out.size() == 1)));
        check_eq("frame_len", 32'(frame_len), 32'(m_len));
        check_eq("err_valid", 32'(err_valid), 32'(m_err != 2'd0));
        check_eq("err_code", 32'(err_code), 32'(m_err));
        check_eq("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic model_step(input bit r, input bit d, input logic [7:0] b, input bit rd);
        int sum;
        int flen;
        if (r) begin
            m_collect = 1'b0;
            m_frame.delete();
            m_out.delete();
            m_gap = 0;
            m_len = 8'd0;
            m_err = 2'd0;
            m_ovr = 1'b0;
            return;
        end
        m_err = 2'd0;
        m_ovr = 1'b0;
        if (m_out.size() > 0) begin
            if (d) m_ovr = 1'b1;
            if (rd) void'(m_out.pop_front());
        end else if (!m_collect) begin
            if (d && (b == SOF)) begin
                m_collect = 1'b1;
                m_frame.delete();
                m_gap = 0;
            end
        end else if (d) begin
            m_frame.push_back(b);
            m_gap = 0;
            flen = int'(m_frame[0]);
            if ((m_frame.size() == 1) && ((flen == 0) || (flen > MAX_LEN))) begin
                m_err = 2'd1;
                m_collect = 1'b0;
            end else if (m_frame.size() == flen + 2) begin
                sum = 0;
                foreach (m_frame[i]) sum += int'(m_frame[i]);
                if ((sum % 256) == 0) begin
                    for (int i = 1; i <= flen; i++) m_out.push_back(m_frame[i]);
                    m_len = m_frame[0];
                end else begin
                    m_err = 2'd2;
                end
                m_collect = 1'b0;
            end
        end else if (m_gap == TO - 1) begin
            m_err = 2'd3;
            m_collect = 1'b0;
        end else begin
            m_gap++;
        end
    endtask

    // One clock: check what the last edge produced, then drive the next inputs.
    task automatic tick(input bit r, input bit d, input logic [7:0] b);
        bit rd;
        @(posedge clk);
        #1;
        check_outputs();
        if (ready_mode == 0)      rd = 1'b1;
        else if (ready_mode == 2) rd = 1'b0;
        else                      rd = 1'($urandom_range(0, 1));
        rst = r;
        dv  = d;
        rxb = d ? b : 8'($urandom);
        rdy = rd;
        model_step(r, d, b, rd);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        idle(gap);
        tick(1'b0, 1'b1, b);
    endtask

    task automatic send_bytes(input byte_q_t q, input int max_gap);
        foreach (q[i]) send_byte(q[i], $urandom_range(0, max_gap));
    endtask

    function automatic byte_q_t make_frame(input int len, input bit corrupt);
        byte_q_t q;
        logic [7:0] s;
        logic [7:0] pb;
        q.push_back(SOF);
        q.push_back(8'(len));
        s = 8'(len);
        for (int i = 0; i < len; i++) begin
            pb = 8'($urandom);
            q.push_back(pb);
            s = s + pb;
        end
        s = 8'd0 - s;
        if (corrupt) s = s + 8'd1;
        q.push_back(s);
        return q;
    endfunction

    initial begin
        byte_q_t q;
        int kind;
        rst = 1'b1;
        dv  = 1'b0;
        rxb = 8'h00;
        rdy = 1'b0;

        // reset state
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);

        // noise, then good frame streamed at full rate
        ready_mode = 0;
        send_bytes('{8'h00, 8'hFF, 8'h13}, 2);
        send_bytes('{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97}, 0);
        idle(8);

        // bad checksum, then good frame
        send_bytes('{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98}, 1);
        idle(4);
        send_bytes('{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97}, 1);
        idle(6);

        // bad lengths, trailing bytes ignored
        send_bytes('{8'h7E, 8'h00, 8'h11, 8'h22}, 1);
        idle(3);
        send_bytes('{8'h7E, 8'h11, 8'h01, 8'h02, 8'h03}, 1);
        idle(3);
        send_bytes('{8'h7E, 8'h01, 8'h5A, 8'hA5}, 0);
        idle(4);

        // timeout fires, then a byte on the last allowed cycle is accepted
        send_bytes('{8'h7E, 8'h02, 8'hAA}, 0);
        idle(TO + 6);
        send_bytes('{8'h7E, 8'h02, 8'hAA}, 0);
        send_byte(8'hAB, TO - 1);
        send_byte(8'hA9, 0);
        idle(6);

        // backpressure with an overrun byte during the stall
        ready_mode = 2;
        send_bytes('{8'h7E, 8'h02, 8'h41, 8'h42, 8'h7B}, 0);
        idle(5);
        send_byte(8'h55, 0);
        idle(14);
        ready_mode = 0;
        idle(5);

        // reset in the middle of a payload, then a fresh frame
        send_bytes('{8'h7E, 8'h04, 8'h01, 8'h02}, 0);
        tick(1'b1, 1'b0, 8'h00);
        idle(2);
        send_bytes('{8'h7E, 8'h02, 8'h41, 8'h42, 8'h7B}, 0);
        idle(5);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            ready_mode = $urandom_range(0, 1);
            kind = $urandom_range(0, 19);
            if (kind == 0) begin
                q = '{SOF, 8'($urandom_range(17, 255))};
                if ($urandom_range(0, 1) == 0) q[1] = 8'h00;
                q.push_back(8'($urandom));
            end else begin
                q = make_frame($urandom_range(1, MAX_LEN), kind == 1);
            end
            if (kind == 2) begin
                repeat ($urandom_range(1, q.size() - 1)) void'(q.pop_back());
            end
            if (kind == 3) send_byte(8'($urandom), 0);
            send_bytes(q, (kind == 4) ? 0 : 3);
            if (kind == 2) idle(TO + 4);
            if (kind == 5) begin
                idle($urandom_range(0, 4));
                tick(1'b1, 1'b0, 8'h00);
            end
            idle($urandom_range(0, 25));
        end

        ready_mode = 0;
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
